pwm_dt_gen: RTL
===============

Name: pwm_dt_gen

Overview:
Parametrised complementary PWM generator with non-overlap (dead time); next generation of the fixed 12-bit motor-drive PWM. Adds a programmable period, a programmable dead time, and double-buffered (shadowed) duty/period/dead-time updates applied only at period boundaries. Also adds an enable and a fault shutdown path. Sits between the control loop (duty source) and the gate-drive outputs.

Parameters:
WIDTH, 12, width of counter, period and duty
DT_WIDTH, 8, width of dead-time value (DT_WIDTH <= WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  run enable; 0 = counter held at 0, outputs low
load  in  1  strobe: capture period/duty/deadtime into shadow
period  in  WIDTH  counter terminal value (period = period+1 clocks)
duty  in  WIDTH  high-side switch point
deadtime  in  DT_WIDTH  non-overlap clocks
fault  in  1  synchronous fault request, forces outputs low
PWM1  out  1  high-side drive
PWM2  out  1  low-side drive
cyc_start  out  1  one-cycle pulse at start of each period
load_pending  out  1  shadow holds values not yet applied
fault_active  out  1  fault shutdown in effect

Behaviour:
- Reset: cnt=0; active per/duty/dt=0; shadow=0; PWM1=PWM2=0; cyc_start=0; load_pending=0; fault_active=0.
- Shadow: load=1 captures inputs into shadow and sets load_pending; a later load overwrites the shadow (last wins).
- Apply: shadow -> active on the edge where cnt==per_a (wrap), or on any edge while en=0; load_pending clears on the same edge. A load coincident with the apply edge is captured and applied at that edge.
- Counter: en=0 -> cnt<=0. en=1 -> cnt<=(cnt==per_a)?0:cnt+1. per_a==0 -> cnt stays 0; PWM1/PWM2 stay 0.
- duty_eff = min(duty_a, per_a); all compares are WIDTH+1 bits wide (no overflow of duty+dt).
- Set/reset terms (combinational from cnt):
  - s1 = cnt>=dt_a; r1 = cnt>=duty_eff
  - s2 = cnt>=duty_eff+dt_a; r2 = cnt==per_a
- Output registers: reset term has priority over set; one-clock latency from cnt to the output.
- Per period (per_a+1 clocks):
  - PWM1 high max(duty_eff-dt_a,0) clocks.
  - PWM2 high max(per_a-duty_eff-dt_a,0) clocks.
  - PWM1 and PWM2 are never high together; each edge has >=dt_a clocks of both-low.
- cyc_start: registered; high the clock after cnt==0 with en=1.
- Fault:
  - fault=1 -> fault_active<=1; PWM1/PWM2 <=0 on the same edge and held low.
  - The counter keeps running during a fault.
  - fault_active clears at a wrap where fault=0; normal switching resumes in the new period.
- en falling mid-period: next edge cnt=0, PWM1=PWM2=0. Shadow is preserved and applied immediately.
- Async reset mid-operation clears everything, including any pending shadow.

Optional Feature:
- Macro PWM_DT_FAULT_LATCH_EN.
- Defined:
  - Adds input fault_clr (1 bit).
  - fault_active is sticky: it clears only on fault_clr=1 while fault=0, effective at the next wrap.
  - fault_clr while fault=1 is ignored.
- Undefined:
  - No fault_clr port.
  - Auto-clear at the first wrap with fault=0, as in Behaviour.

Test Plan:
- WIDTH=12, period=99, duty=50, dt=10 -> PWM1 high 40 clocks, PWM2 high 39 clocks per 100-clock period; >=10 both-low clocks at each edge.
- duty=5, dt=10 -> PWM1 never high; PWM2 high 84 clocks. duty=200 (clamped to 99) -> PWM1 high 89 clocks; PWM2 never high.
- Mid-period load with duty=70 -> load_pending=1 until wrap; old waveform finishes; new duty takes effect from the next cyc_start; pending clears at wrap.
- Max values: period=4095, duty=4095, dt=255 -> no compare overflow; PWM2 stays 0; PWM1 high 3840 clocks.
- fault pulse at cnt=30 -> both outputs low next edge; fault_active=1 until wrap; resume in next period. With macro: stays 1 until fault_clr, then the next wrap.
- Reset asserted at cnt=60 with PWM1=1 -> all outputs 0 immediately; after release cnt restarts at 0 with active regs 0 (outputs low until load).

Source files
------------

// File: rtl/pwm_dt_gen.sv
// pwm_dt_gen -- complementary PWM generator with dead time (non-overlap).
//
// An up-counter runs 0..per_a and wraps.  The high-side output (PWM1) and
// the low-side output (PWM2) are set/reset registers driven by compares
// against the counter, so the two outputs are never high together.
// Duty, period and dead time are written into a shadow copy by a load
// strobe and copied to the active copy only at a wrap, or on any edge while
// the generator is disabled.  A fault forces both outputs low.
//
// Build option: define PWM_DT_FAULT_LATCH_EN to make the fault flag sticky.
// It then clears only after fault_clr (with fault low), at the next wrap.
//
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   en            run enable (0: counter held at 0, outputs low)
//   load          strobe: capture period/duty/deadtime into the shadow
//   period        counter terminal value (period+1 clocks per cycle)
//   duty          high-side switch point
//   deadtime      non-overlap clocks
//   fault         synchronous fault request, forces outputs low
//   fault_clr     (PWM_DT_FAULT_LATCH_EN only) releases a latched fault
//   PWM1, PWM2    high-side / low-side gate drive
//   cyc_start     one-clock pulse at the start of each period
//   load_pending  shadow holds values not yet applied
//   fault_active  fault shutdown in effect
module pwm_dt_gen #(
  parameter int WIDTH    = 12,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    period,
  input  logic [WIDTH-1:0]    duty,
  input  logic [DT_WIDTH-1:0] deadtime,
  input  logic                fault,
`ifdef PWM_DT_FAULT_LATCH_EN
  input  logic                fault_clr,
`endif
  output logic                PWM1,
  output logic                PWM2,
  output logic                cyc_start,
  output logic                load_pending,
  output logic                fault_active
);

  // Compares are one bit wider than the counter so duty+deadtime never wraps.
  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_per_a, r_duty_a, r_per_s, r_duty_s;
  logic [DT_WIDTH-1:0] r_dt_a, r_dt_s;
  logic                r_pending;
  logic                r_pwm1, r_pwm2;
  logic                r_cyc_start;
  logic                r_fault_active;

  logic [WIDTH-1:0] w_duty_eff;
  logic [EW-1:0]    w_cnt_x, w_dt_x, w_s2_thr;
  logic             w_at_per, w_wrap, w_apply, w_force_low;
  logic             w_s1, w_r1, w_s2, w_r2;

  assign w_at_per    = (r_cnt == r_per_a);
  assign w_wrap      = en && w_at_per;
  // Disabled generator takes new settings immediately.
  assign w_apply     = w_wrap || !en;
  assign w_force_low = !en || fault || r_fault_active;

  assign w_duty_eff = (r_duty_a > r_per_a) ? r_per_a : r_duty_a;
  assign w_cnt_x    = {1'b0, r_cnt};
  assign w_dt_x     = {{(EW-DT_WIDTH){1'b0}}, r_dt_a};
  assign w_s2_thr   = {1'b0, w_duty_eff} + w_dt_x;

  assign w_s1 = (w_cnt_x >= w_dt_x);
  assign w_r1 = (r_cnt >= w_duty_eff);
  assign w_s2 = (w_cnt_x >= w_s2_thr);
  assign w_r2 = w_at_per;

  // Counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || w_at_per) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  // Shadow and active settings.  A load on the apply edge goes straight
  // through to the active copy so it is not lost or delayed a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_s   <= '0;
      r_duty_s  <= '0;
      r_dt_s    <= '0;
      r_per_a   <= '0;
      r_duty_a  <= '0;
      r_dt_a    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load) begin
        r_per_s  <= period;
        r_duty_s <= duty;
        r_dt_s   <= deadtime;
      end
      if (w_apply) begin
        if (load) begin
          r_per_a  <= period;
          r_duty_a <= duty;
          r_dt_a   <= deadtime;
        end else if (r_pending) begin
          r_per_a  <= r_per_s;
          r_duty_a <= r_duty_s;
          r_dt_a   <= r_dt_s;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Output set/reset registers; reset term wins over set term.  Both
  // outputs are reset at the wrap, so every period starts with both low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm1      <= 1'b0;
      r_pwm2      <= 1'b0;
      r_cyc_start <= 1'b0;
    end else begin
      r_cyc_start <= en && (r_cnt == '0);
      if (w_force_low || w_r1) begin
        r_pwm1 <= 1'b0;
      end else if (w_s1) begin
        r_pwm1 <= 1'b1;
      end
      if (w_force_low || w_r2) begin
        r_pwm2 <= 1'b0;
      end else if (w_s2) begin
        r_pwm2 <= 1'b1;
      end
    end
  end

  // Fault flag.  It only ever clears at a wrap, so switching always
  // resumes at the start of a fresh period.
`ifdef PWM_DT_FAULT_LATCH_EN
  logic r_clr_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_active <= 1'b0;
      r_clr_req      <= 1'b0;
    end else if (fault) begin
      r_fault_active <= 1'b1;
      r_clr_req      <= 1'b0;
    end else begin
      if (fault_clr && r_fault_active) begin
        r_clr_req <= 1'b1;
      end
      if (w_wrap && r_fault_active && (r_clr_req || fault_clr)) begin
        r_fault_active <= 1'b0;
        r_clr_req      <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_active <= 1'b0;
    end else if (fault) begin
      r_fault_active <= 1'b1;
    end else if (w_wrap) begin
      r_fault_active <= 1'b0;
    end
  end
`endif

  assign PWM1         = r_pwm1;
  assign PWM2         = r_pwm2;
  assign cyc_start    = r_cyc_start;
  assign load_pending = r_pending;
  assign fault_active = r_fault_active;

endmodule
